// File: rtl/seq_divider_8x4_pkg.sv
// Shared definitions for the sequential 8x4 restoring divider: FSM encoding,
// default widths and the iteration-counter width helper.
package seq_divider_8x4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  // Counter must be able to hold the value DW itself.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, used as the ripple element
// of the divider's subtract-and-select stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_divider_8x4_div_step.sv
// One restoring-division step: trial subtract r_shift - {0,d} on a ripple of
// full adders; a carry out (no borrow) keeps the difference and emits a 1.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_shift,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW:0]   d_inv;
  logic [VW:0]   diff;
  logic [VW+1:0] carry;

  // Two's-complement subtract: r + ~{0,d} + 1.
  assign d_inv    = ~{1'b0, d};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= VW; i++) begin : g_sub
    full_adder u_fa (
      .a    (r_shift[i]),
      .b    (d_inv[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign q_bit  = carry[VW+1];
  assign r_next = q_bit ? diff : r_shift;

endmodule

// File: rtl/seq_divider_8x4.sv
// Unsigned iterative restoring divider, DW/VW -> DW quotient + VW remainder, one bit per clock.
// Result appears DW edges after accept and is held until out_ready; SEQ_DIVIDER_DBZ_CHECK_EN adds a fast divide-by-zero path.
module seq_divider_8x4
  import seq_divider_8x4_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = cnt_width(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  state_t        state;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [CW-1:0] cnt;

  logic [VW:0]   r_shift;
  logic [VW:0]   r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;

  // After a step R < D, so its top bit only matters inside div_step.
  logic unused_r_msb;
  assign unused_r_msb = r_reg[VW];

  assign r_shift = {r_reg[VW-1:0], q_reg[DW-1]};
  assign q_next  = {q_reg[DW-2:0], q_bit};

  div_step #(.VW(VW)) u_step (
    .r_shift (r_shift),
    .d       (d_reg),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
  logic dbz_q;
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= dividend;
            d_reg    <= divisor;
            r_reg    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              dbz_q     <= 1'b1;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[VW-1:0];
`ifdef SEQ_DIVIDER_DBZ_CHECK_EN
            dbz_q     <= 1'b0;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
